// File: rtl/sram_uart_dump.sv
// sram_uart_dump: reads a contiguous SRAM word range and streams it out as 8N1 UART frames, high byte first.
// Defining DUMP_CHECKSUM_EN appends a 16-bit modular checksum trailer (two frames) after the last word.
module sram_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SRAM_LAT     = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic [17:0] base_address,
  input  logic [17:0] word_count,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2((CLKS_PER_BIT > SRAM_LAT) ? CLKS_PER_BIT : SRAM_LAT) + 1;

  typedef enum logic [2:0] {
    S_DUMP_IDLE,
    S_DUMP_ADDR,
    S_DUMP_WAIT,
    S_DUMP_LATCH,
    S_DUMP_TX_HI,
    S_DUMP_TX_LO,
    S_DUMP_DONE
`ifdef DUMP_CHECKSUM_EN
    , S_DUMP_TX_CSUM
`endif
  } state_t;

`ifdef DUMP_CHECKSUM_EN
  localparam state_t TAIL_STATE = S_DUMP_TX_CSUM;
`else
  localparam state_t TAIL_STATE = S_DUMP_DONE;
`endif

  state_t          state_r, state_s;
  logic [17:0]     addr_r, addr_s;
  logic [17:0]     remain_r, remain_s;
  logic [15:0]     word_r, word_s;
  logic [CW-1:0]   clk_cnt_r, clk_cnt_s;
  logic [4:0]      bit_cnt_r, bit_cnt_s;
  logic            tx_r, tx_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            bit_end_s;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0]     csum_r, csum_s;
`endif

  // Frame layout {stop, data, start}; indices past the stop bit read as idle-high.
  function automatic logic frame_bit(input logic [7:0] data, input logic [4:0] idx);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    if (idx < 5'd10) begin
      frame_bit = frame[idx[3:0]];
    end else begin
      frame_bit = 1'b1;
    end
  endfunction

  // Next-state, datapath and line value; tx is registered so the line lags the bit counters by one cycle.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    remain_s  = remain_r;
    word_s    = word_r;
    clk_cnt_s = clk_cnt_r;
    bit_cnt_s = bit_cnt_r;
    tx_s      = 1'b1;
    busy_s    = busy_r;
    done_s    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_s    = csum_r;
`endif
    bit_end_s = (clk_cnt_r == CW'(CLKS_PER_BIT - 1));
    case (state_r)
      S_DUMP_IDLE: begin
        if (start) begin
          addr_s    = base_address;
          remain_s  = word_count;
          busy_s    = 1'b1;
          clk_cnt_s = {CW{1'b0}};
          bit_cnt_s = 5'd0;
`ifdef DUMP_CHECKSUM_EN
          csum_s    = 16'd0;
`endif
          if (word_count == 18'd0) begin
            state_s = TAIL_STATE;
          end else begin
            state_s = S_DUMP_ADDR;
          end
        end else begin
          state_s = S_DUMP_IDLE;
        end
      end
      S_DUMP_ADDR: begin
        clk_cnt_s = {CW{1'b0}};
        state_s   = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (clk_cnt_r == CW'(SRAM_LAT - 2)) begin
          state_s = S_DUMP_LATCH;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
      S_DUMP_LATCH: begin
        word_s    = SRAM_read_data;
        addr_s    = addr_r + 18'd1;
        remain_s  = remain_r - 18'd1;
        clk_cnt_s = {CW{1'b0}};
        bit_cnt_s = 5'd0;
`ifdef DUMP_CHECKSUM_EN
        csum_s    = csum_r + SRAM_read_data;
`endif
        state_s   = S_DUMP_TX_HI;
      end
      S_DUMP_TX_HI: begin
        tx_s = frame_bit(word_r[15:8], bit_cnt_r);
        if (bit_end_s) begin
          clk_cnt_s = {CW{1'b0}};
          if (bit_cnt_r == 5'd9) begin
            bit_cnt_s = 5'd0;
            state_s   = S_DUMP_TX_LO;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
      S_DUMP_TX_LO: begin
        tx_s = frame_bit(word_r[7:0], bit_cnt_r);
        // Linger one cycle past bit 9 so the state leaves when the stop bit ends on the line.
        if (bit_cnt_r == 5'd10) begin
          clk_cnt_s = {CW{1'b0}};
          bit_cnt_s = 5'd0;
          if (remain_r != 18'd0) begin
            state_s = S_DUMP_ADDR;
          end else begin
            state_s = TAIL_STATE;
          end
        end else if (bit_end_s) begin
          clk_cnt_s = {CW{1'b0}};
          bit_cnt_s = bit_cnt_r + 5'd1;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_DUMP_TX_CSUM: begin
        if (bit_cnt_r < 5'd10) begin
          tx_s = frame_bit(csum_r[15:8], bit_cnt_r);
        end else begin
          tx_s = frame_bit(csum_r[7:0], bit_cnt_r - 5'd10);
        end
        if (bit_cnt_r == 5'd20) begin
          clk_cnt_s = {CW{1'b0}};
          bit_cnt_s = 5'd0;
          state_s   = S_DUMP_DONE;
        end else if (bit_end_s) begin
          clk_cnt_s = {CW{1'b0}};
          bit_cnt_s = bit_cnt_r + 5'd1;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
`endif
      S_DUMP_DONE: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = S_DUMP_IDLE;
      end
      default: begin
        state_s = S_DUMP_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and returns the line high at once.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_DUMP_IDLE;
      addr_r    <= 18'd0;
      remain_r  <= 18'd0;
      word_r    <= 16'd0;
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= 5'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_r    <= 16'd0;
`endif
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      remain_r  <= remain_s;
      word_r    <= word_s;
      clk_cnt_r <= clk_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
`ifdef DUMP_CHECKSUM_EN
      csum_r    <= csum_s;
`endif
    end
  end

  assign SRAM_address = addr_r;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
